// File: rtl/amm_arb_pkg.sv
// Shared types and helpers for the Avalon-MM requester arbiter.
// ID_W is sized for the largest supported requester count so every configuration shares one width.
package amm_arb_pkg;

    localparam int MAX_MASTERS = 8;
    localparam int ID_W        = $clog2(MAX_MASTERS);

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Round-robin pick: first set request after 'last', wrapping modulo n.
    function automatic logic [ID_W-1:0] rr_pick(
        input logic [MAX_MASTERS-1:0] req,
        input logic [ID_W-1:0]        last,
        input int                     n
    );
        logic [ID_W-1:0] pick;
        logic [ID_W-1:0] idx_s;
        logic            found;
        int              idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= MAX_MASTERS; k++) begin
            idx   = (int'(last) + k) % n;
            idx_s = idx[ID_W-1:0];
            if (!found && (k <= n) && req[idx_s]) begin
                pick  = idx_s;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/amm_arb_id_fifo.sv
// In-order FIFO of requester IDs for outstanding reads; head names the owner of the next response.
module amm_arb_id_fifo
    import amm_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ID_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full  = (count_q == (PW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    // Pointer and occupancy update; depth is a power of two so pointers wrap naturally.
    always_comb begin
        push_ok_s = push & ~full;
        pop_ok_s  = pop & ~empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/amm_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master port between NUM_MASTERS requesters,
// with an ID FIFO routing each read response back to its issuer.
module amm_arbiter
    import amm_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int AMM_ADDR_WIDTH = 32,
    parameter int MAX_PENDING    = 4
) (
    input  logic                                  main_clk,
    input  logic                                  main_reset_n,
    input  logic [NUM_MASTERS*AMM_ADDR_WIDTH-1:0] s_address,
    input  logic [NUM_MASTERS*32-1:0]             s_writedata,
    input  logic [NUM_MASTERS-1:0]                s_write,
    input  logic [NUM_MASTERS-1:0]                s_read,
    output logic [NUM_MASTERS-1:0]                s_waitrequest,
    output logic [31:0]                           s_readdata,
    output logic [NUM_MASTERS-1:0]                s_readdatavalid,
    output logic [AMM_ADDR_WIDTH-1:0]             m_address,
    output logic [31:0]                           m_writedata,
    output logic                                  m_write,
    output logic                                  m_read,
    input  logic [31:0]                           m_readdata,
    input  logic                                  m_readdatavalid,
    input  logic                                  m_waitrequest,
    output logic [$clog2(MAX_PENDING):0]          pending_cnt,
    output logic                                  protocol_err
);

    arb_state_t          state_q, state_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [ID_W-1:0]     last_grant_q, last_grant_d;
    logic                err_q, err_d;

    logic [AMM_ADDR_WIDTH-1:0] addr_arr [MAX_MASTERS];
    logic [31:0]               data_arr [MAX_MASTERS];
    logic [MAX_MASTERS-1:0]    wr_pad;
    logic [MAX_MASTERS-1:0]    rd_pad;
    logic [MAX_MASTERS-1:0]    req_pad;

    logic                sel_wr_s;
    logic                sel_rd_s;
    logic                wait_sel_s;
    logic                err_set_s;
    logic                push_s;
    logic                pop_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [ID_W-1:0]     fifo_head_s;

    // Requester slices padded to MAX_MASTERS so the grant index never leaves the vector.
    for (genvar i = 0; i < MAX_MASTERS; i++) begin : g_pad
        if (i < NUM_MASTERS) begin : g_used
            assign addr_arr[i] = s_address[i*AMM_ADDR_WIDTH +: AMM_ADDR_WIDTH];
            assign data_arr[i] = s_writedata[i*32 +: 32];
            assign wr_pad[i]   = s_write[i];
            assign rd_pad[i]   = s_read[i];
        end else begin : g_unused
            assign addr_arr[i] = '0;
            assign data_arr[i] = '0;
            assign wr_pad[i]   = 1'b0;
            assign rd_pad[i]   = 1'b0;
        end
    end

    assign req_pad    = wr_pad | rd_pad;
    assign s_readdata = m_readdata;

    // Arbitration FSM and command mux; a write wins when both strobes are raised.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        sel_wr_s     = 1'b0;
        sel_rd_s     = 1'b0;
        wait_sel_s   = 1'b1;
        err_set_s    = 1'b0;
        push_s       = 1'b0;
        m_address    = '0;
        m_writedata  = 32'h0000_0000;
        m_write      = 1'b0;
        m_read       = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (|req_pad) begin
                    grant_d = rr_pick(req_pad, last_grant_q, NUM_MASTERS);
                    state_d = ARB_BUSY;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_BUSY: begin
                sel_wr_s    = wr_pad[grant_q];
                sel_rd_s    = rd_pad[grant_q] & ~sel_wr_s;
                m_address   = addr_arr[grant_q];
                m_writedata = data_arr[grant_q];
                m_write     = sel_wr_s;
                m_read      = sel_rd_s & ~fifo_full_s;
                wait_sel_s  = m_waitrequest | (sel_rd_s & fifo_full_s);
                if (wr_pad[grant_q] & rd_pad[grant_q]) begin
                    err_set_s = 1'b1;
                end else begin
                    err_set_s = 1'b0;
                end
                if ((m_read | m_write) & ~m_waitrequest) begin
                    push_s       = m_read;
                    last_grant_d = grant_q;
                    state_d      = ARB_IDLE;
                end else if (!req_pad[grant_q]) begin
                    // Requester withdrew its command while stalled.
                    err_set_s    = 1'b1;
                    last_grant_d = grant_q;
                    state_d      = ARB_IDLE;
                end else begin
                    state_d = ARB_BUSY;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Per-requester stall and response qualifiers, plus the sticky error update.
    always_comb begin
        s_waitrequest   = '1;
        s_readdatavalid = '0;
        pop_s           = m_readdatavalid & ~fifo_empty_s;
        err_d           = err_q | err_set_s | (m_readdatavalid & fifo_empty_s);
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if ((state_q == ARB_BUSY) && (grant_q == ID_W'(i))) begin
                s_waitrequest[i] = wait_sel_s;
            end else begin
                s_waitrequest[i] = 1'b1;
            end
            s_readdatavalid[i] = pop_s & (fifo_head_s == ID_W'(i));
        end
    end

    // FSM, grant and error registers.
    always_ff @(posedge main_clk or negedge main_reset_n) begin
        if (!main_reset_n) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_W'(NUM_MASTERS - 1);
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
        end
    end

    assign protocol_err = err_q;

    amm_arb_id_fifo #(
        .DEPTH (MAX_PENDING),
        .WIDTH (ID_W)
    ) u_id_fifo (
        .clk   (main_clk),
        .rst_n (main_reset_n),
        .push  (push_s),
        .din   (grant_q),
        .pop   (pop_s),
        .head  (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (pending_cnt)
    );

endmodule

// File: tb/tb_amm_arbiter.sv
// Directed self-checking bench for amm_arbiter with three requesters and four pending reads.
module tb_amm_arbiter;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int MP = 4;

    logic            main_clk = 1'b0;
    logic            main_reset_n = 1'b1;
    logic [NM*AW-1:0] s_address;
    logic [NM*32-1:0] s_writedata;
    logic [NM-1:0]   s_write;
    logic [NM-1:0]   s_read;
    logic [NM-1:0]   s_waitrequest;
    logic [31:0]     s_readdata;
    logic [NM-1:0]   s_readdatavalid;
    logic [AW-1:0]   m_address;
    logic [31:0]     m_writedata;
    logic            m_write;
    logic            m_read;
    logic [31:0]     m_readdata;
    logic            m_readdatavalid;
    logic            m_waitrequest;
    logic [2:0]      pending_cnt;
    logic            protocol_err;

    int checks = 0;
    int failures = 0;

    amm_arbiter #(
        .NUM_MASTERS    (NM),
        .AMM_ADDR_WIDTH (AW),
        .MAX_PENDING    (MP)
    ) dut (
        .main_clk        (main_clk),
        .main_reset_n    (main_reset_n),
        .s_address       (s_address),
        .s_writedata     (s_writedata),
        .s_write         (s_write),
        .s_read          (s_read),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .m_address       (m_address),
        .m_writedata     (m_writedata),
        .m_write         (m_write),
        .m_read          (m_read),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .m_waitrequest   (m_waitrequest),
        .pending_cnt     (pending_cnt),
        .protocol_err    (protocol_err)
    );

    always #5 main_clk = ~main_clk;

    task automatic tick();
        @(posedge main_clk);
        #2;
    endtask

    task automatic clear_inputs();
        s_address       = '0;
        s_writedata     = '0;
        s_write         = '0;
        s_read          = '0;
        m_readdata      = 32'h0;
        m_readdatavalid = 1'b0;
        m_waitrequest   = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        main_reset_n = 1'b0;
        tick();
        tick();
        main_reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        #1;
        main_reset_n = 1'b0;
        tick();
        checks++; if (s_waitrequest !== 3'b111) begin failures++; $display("FAIL reset_wait: got %b want 111", s_waitrequest); end
        checks++; if (s_readdatavalid !== 3'b000) begin failures++; $display("FAIL reset_rdv: got %b want 000", s_readdatavalid); end
        checks++; if ({m_read, m_write} !== 2'b00) begin failures++; $display("FAIL reset_strobes: got %b want 00", {m_read, m_write}); end
        checks++; if (m_address !== 32'h0 || m_writedata !== 32'h0) begin failures++; $display("FAIL reset_bus: addr %h data %h want 0", m_address, m_writedata); end
        checks++; if (pending_cnt !== 3'd0 || protocol_err !== 1'b0) begin failures++; $display("FAIL reset_status: cnt %0d err %b want 0 0", pending_cnt, protocol_err); end
        main_reset_n = 1'b1;
    endtask

    task automatic test_single_write();
        do_reset();
        s_write[0] = 1'b1;
        s_address[31:0] = 32'h0000_1000;
        s_writedata[31:0] = 32'hDEAD_BEEF;
        #1;
        checks++; if (m_write !== 1'b0) begin failures++; $display("FAIL wr_idle: m_write %b want 0", m_write); end
        tick();
        checks++; if (m_write !== 1'b1) begin failures++; $display("FAIL wr_strobe: m_write %b want 1", m_write); end
        checks++; if (m_address !== 32'h0000_1000) begin failures++; $display("FAIL wr_addr: got %h want 00001000", m_address); end
        checks++; if (m_writedata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_data: got %h want deadbeef", m_writedata); end
        checks++; if (s_waitrequest !== 3'b110) begin failures++; $display("FAIL wr_wait: got %b want 110", s_waitrequest); end
        tick();
        s_write = '0;
        #1;
        checks++; if (m_write !== 1'b0 || s_waitrequest !== 3'b111) begin failures++; $display("FAIL wr_done: m_write %b wait %b want 0 111", m_write, s_waitrequest); end
    endtask

    task automatic test_round_robin();
        int exp_g [6] = '{0, 1, 2, 0, 1, 2};
        int n = 0;
        int g;
        do_reset();
        for (int i = 0; i < NM; i++) begin
            s_address[i*32 +: 32] = 32'h100 * (i + 1);
        end
        s_write = 3'b111;
        for (int c = 0; c < 30 && n < 6; c++) begin
            tick();
            if (m_write) begin
                g = 7;
                for (int k = 0; k < NM; k++) begin
                    if (!s_waitrequest[k]) g = k;
                end
                checks++; if (g !== exp_g[n]) begin failures++; $display("FAIL rr_order[%0d]: got %0d want %0d", n, g, exp_g[n]); end
                checks++; if (m_address !== 32'h100 * (exp_g[n] + 1)) begin failures++; $display("FAIL rr_addr[%0d]: got %h want %h", n, m_address, 32'h100 * (exp_g[n] + 1)); end
                n++;
            end
        end
        checks++; if (n != 6) begin failures++; $display("FAIL rr_count: got %0d grants want 6", n); end
        s_write = '0;
    endtask

    task automatic test_pipelined_reads();
        do_reset();
        s_read[0] = 1'b1;
        s_address[31:0] = 32'h10;
        tick();
        checks++; if (m_read !== 1'b1 || m_address !== 32'h10) begin failures++; $display("FAIL pr_rd0: m_read %b addr %h want 1 10", m_read, m_address); end
        tick();
        s_read = '0;
        s_read[1] = 1'b1;
        s_address[63:32] = 32'h20;
        #1;
        checks++; if (pending_cnt !== 3'd1) begin failures++; $display("FAIL pr_cnt1: got %0d want 1", pending_cnt); end
        tick();
        checks++; if (m_read !== 1'b1 || m_address !== 32'h20) begin failures++; $display("FAIL pr_rd1: m_read %b addr %h want 1 20", m_read, m_address); end
        tick();
        s_read = '0;
        #1;
        checks++; if (pending_cnt !== 3'd2) begin failures++; $display("FAIL pr_cnt2: got %0d want 2", pending_cnt); end
        tick();
        tick();
        m_readdatavalid = 1'b1;
        m_readdata = 32'h1111_1111;
        #1;
        checks++; if (s_readdatavalid !== 3'b001 || s_readdata !== 32'h1111_1111) begin failures++; $display("FAIL pr_resp0: rdv %b data %h want 001 11111111", s_readdatavalid, s_readdata); end
        tick();
        m_readdatavalid = 1'b0;
        #1;
        checks++; if (pending_cnt !== 3'd1) begin failures++; $display("FAIL pr_cnt3: got %0d want 1", pending_cnt); end
        tick();
        m_readdatavalid = 1'b1;
        m_readdata = 32'h2222_2222;
        #1;
        checks++; if (s_readdatavalid !== 3'b010 || s_readdata !== 32'h2222_2222) begin failures++; $display("FAIL pr_resp1: rdv %b data %h want 010 22222222", s_readdatavalid, s_readdata); end
        tick();
        m_readdatavalid = 1'b0;
        #1;
        checks++; if (pending_cnt !== 3'd0) begin failures++; $display("FAIL pr_cnt4: got %0d want 0", pending_cnt); end
    endtask

    task automatic test_fifo_full();
        int acc = 0;
        do_reset();
        s_read[0] = 1'b1;
        s_address[31:0] = 32'h40;
        for (int c = 0; c < 40 && acc < 4; c++) begin
            tick();
            if (m_read && !s_waitrequest[0]) acc++;
        end
        checks++; if (acc != 4) begin failures++; $display("FAIL ff_issue: got %0d reads want 4", acc); end
        tick();
        checks++; if (pending_cnt !== 3'd4) begin failures++; $display("FAIL ff_cnt4: got %0d want 4", pending_cnt); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (m_read !== 1'b0 || s_waitrequest[0] !== 1'b1) begin failures++; $display("FAIL ff_hold[%0d]: m_read %b wait %b want 0 1", c, m_read, s_waitrequest[0]); end
        end
        m_readdatavalid = 1'b1;
        m_readdata = 32'hAAAA_5555;
        #1;
        checks++; if (s_readdatavalid !== 3'b001 || m_read !== 1'b0) begin failures++; $display("FAIL ff_pop: rdv %b m_read %b want 001 0", s_readdatavalid, m_read); end
        tick();
        m_readdatavalid = 1'b0;
        #1;
        checks++; if (m_read !== 1'b1 || s_waitrequest[0] !== 1'b0 || pending_cnt !== 3'd3) begin failures++; $display("FAIL ff_release: m_read %b wait %b cnt %0d want 1 0 3", m_read, s_waitrequest[0], pending_cnt); end
        tick();
        s_read = '0;
        #1;
        checks++; if (pending_cnt !== 3'd4) begin failures++; $display("FAIL ff_cnt_refill: got %0d want 4", pending_cnt); end
    endtask

    task automatic test_stall();
        do_reset();
        m_waitrequest = 1'b1;
        s_write[1] = 1'b1;
        s_address[63:32] = 32'h2000;
        s_writedata[63:32] = 32'hCAFE_F00D;
        tick();
        s_write[0] = 1'b1;
        s_write[2] = 1'b1;
        s_address[31:0] = 32'h3000;
        s_address[95:64] = 32'h4000;
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++; if (m_write !== 1'b1 || m_address !== 32'h2000 || m_writedata !== 32'hCAFE_F00D || s_waitrequest !== 3'b111) begin
                failures++; $display("FAIL stall_hold[%0d]: wr %b addr %h data %h wait %b", c, m_write, m_address, m_writedata, s_waitrequest);
            end
            tick();
        end
        m_waitrequest = 1'b0;
        #1;
        checks++; if (s_waitrequest !== 3'b101 || m_address !== 32'h2000) begin failures++; $display("FAIL stall_accept: wait %b addr %h want 101 2000", s_waitrequest, m_address); end
        tick();
        s_write[1] = 1'b0;
        tick();
        checks++; if (s_waitrequest !== 3'b011 || m_address !== 32'h4000) begin failures++; $display("FAIL stall_next: wait %b addr %h want 011 4000", s_waitrequest, m_address); end
        s_write = '0;
    endtask

    task automatic test_dual_strobe();
        do_reset();
        s_read[0] = 1'b1;
        s_write[0] = 1'b1;
        s_address[31:0] = 32'h70;
        tick();
        checks++; if (m_write !== 1'b1 || m_read !== 1'b0) begin failures++; $display("FAIL dual_cmd: wr %b rd %b want 1 0", m_write, m_read); end
        tick();
        s_read = '0;
        s_write = '0;
        #1;
        checks++; if (pending_cnt !== 3'd0 || protocol_err !== 1'b1) begin failures++; $display("FAIL dual_status: cnt %0d err %b want 0 1", pending_cnt, protocol_err); end
    endtask

    task automatic test_errors_reset();
        do_reset();
        m_readdatavalid = 1'b1;
        #1;
        checks++; if (s_readdatavalid !== 3'b000) begin failures++; $display("FAIL err_stray_rdv: got %b want 000", s_readdatavalid); end
        tick();
        m_readdatavalid = 1'b0;
        #1;
        checks++; if (protocol_err !== 1'b1) begin failures++; $display("FAIL err_set: got %b want 1", protocol_err); end
        tick();
        tick();
        checks++; if (protocol_err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b want 1", protocol_err); end
        s_read[0] = 1'b1;
        s_address[31:0] = 32'h50;
        tick();
        tick();
        s_read = '0;
        s_read[1] = 1'b1;
        s_address[63:32] = 32'h60;
        tick();
        tick();
        s_read = '0;
        #1;
        checks++; if (pending_cnt !== 3'd2) begin failures++; $display("FAIL err_pending: got %0d want 2", pending_cnt); end
        s_write[2] = 1'b1;
        s_address[95:64] = 32'h80;
        s_writedata[95:64] = 32'h1234_5678;
        tick();
        checks++; if (m_write !== 1'b1) begin failures++; $display("FAIL err_busy: m_write %b want 1", m_write); end
        #2;
        main_reset_n = 1'b0;
        #1;
        checks++; if (pending_cnt !== 3'd0 || protocol_err !== 1'b0) begin failures++; $display("FAIL arst_status: cnt %0d err %b want 0 0", pending_cnt, protocol_err); end
        checks++; if ({m_read, m_write} !== 2'b00 || m_address !== 32'h0 || m_writedata !== 32'h0) begin failures++; $display("FAIL arst_bus: rd %b wr %b addr %h data %h", m_read, m_write, m_address, m_writedata); end
        checks++; if (s_waitrequest !== 3'b111 || s_readdatavalid !== 3'b000) begin failures++; $display("FAIL arst_slave: wait %b rdv %b want 111 000", s_waitrequest, s_readdatavalid); end
        clear_inputs();
        tick();
        main_reset_n = 1'b1;
        m_readdatavalid = 1'b1;
        #1;
        checks++; if (s_readdatavalid !== 3'b000) begin failures++; $display("FAIL late_rdv: got %b want 000", s_readdatavalid); end
        tick();
        m_readdatavalid = 1'b0;
        #1;
        checks++; if (protocol_err !== 1'b1) begin failures++; $display("FAIL late_err: got %b want 1", protocol_err); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_pipelined_reads();
        test_fifo_full();
        test_stall();
        test_dual_strobe();
        test_errors_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
